// File: rtl/freq_gate_ctrl_if.sv
// -----------------------------------------------------------------------------
// freq_gate_ctrl_if
//
// Purpose:
//   Bundles the request, test-signal and result signals exchanged between the
//   frequency/phase gate sequencer and its surroundings.
//
// Signals:
//   start   1      one-cycle request to begin a measurement
//   sig_a   1      synchronised test signal A (gate reference)
//   sig_b   1      synchronised test signal B (phase target)
//   busy    1      measurement in progress
//   done    1      one-cycle pulse when the results below are updated
//   err     1      last measurement timed out or a counter saturated
//   nx      CNT_W  A periods counted across the gate
//   ns      CNT_W  clk cycles counted across the gate
//   ph      CNT_W  clk cycles from the gate-opening A edge to the first B edge
//   ph_vld  1      ph is meaningful
//
// Modports:
//   master  stimulus / consumer side (drives start, sig_a, sig_b)
//   slave   sequencer side (drives the status and result signals)
//
// CNT_W must match the CNT_W of the freq_gate_ctrl instance it connects to.
// -----------------------------------------------------------------------------
interface freq_gate_ctrl_if #(
    parameter int unsigned CNT_W = 32
);

    logic             start;
    logic             sig_a;
    logic             sig_b;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] nx;
    logic [CNT_W-1:0] ns;
    logic [CNT_W-1:0] ph;
    logic             ph_vld;

    modport master (
        output start, sig_a, sig_b,
        input  busy, done, err, nx, ns, ph, ph_vld
    );

    modport slave (
        input  start, sig_a, sig_b,
        output busy, done, err, nx, ns, ph, ph_vld
    );

endinterface

// File: rtl/freq_gate_ctrl.sv
// -----------------------------------------------------------------------------
// freq_gate_ctrl
//
// Purpose:
//   Equal-precision gate sequencer for the frequency/phase meter path.
//   After a start request the gate opens on a rising edge of A, stays open
//   for at least GATE_CYCLES clocks and closes on the first rising edge of A
//   after that. Across the gate it counts A periods (nx) and reference clocks
//   (ns), and measures the delay from the opening A edge to the first rising
//   edge of B (ph). Results are latched and announced with a one-cycle done
//   pulse. Waiting for the opening or the closing edge is bounded by
//   TMO_CYCLES clocks; an expired wait aborts with err set and zero results.
//
// Parameters:
//   GATE_CYCLES  minimum gate length in clk cycles, 2 .. 2^CNT_W-2
//   TMO_CYCLES   abort limit in clk cycles for the ARM and CLOSE waits
//   CNT_W        width of the Nx, Ns and phase counters and results
//
// Ports:
//   clk   in     system clock
//   rst   in     synchronous reset, active-high
//   bus   slave  freq_gate_ctrl_if: start, sig_a, sig_b in;
//                busy, done, err, nx, ns, ph, ph_vld out (all registered)
// -----------------------------------------------------------------------------
module freq_gate_ctrl #(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int unsigned TMO_CYCLES  = 100000000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic            clk,
    input  logic            rst,
    freq_gate_ctrl_if.slave bus
);

    localparam int unsigned TMO_W = $clog2(TMO_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    // gate_cnt holds (clocks since the opening edge) - 1. The last GATE cycle
    // is GATE_CYCLES-1 clocks after the opening edge, so an A edge exactly
    // GATE_CYCLES clocks after opening is already seen in CLOSE and ends the
    // gate; a clean period P dividing GATE_CYCLES then gives ns = GATE_CYCLES.
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_GATE,
        S_CLOSE,
        S_DONE
    } state_t;

    state_t           state;

    // Edge detection on the already-synchronised test signals.
    logic             sig_a_d;
    logic             sig_b_d;
    logic             rise_a;
    logic             rise_b;

    // Measurement counters.
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] cnt_x;
    logic [CNT_W-1:0] ph_cnt;
    logic [CNT_W-1:0] gate_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             ph_seen;

    // Registered outputs.
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             ph_vld_q;
    logic [CNT_W-1:0] nx_q;
    logic [CNT_W-1:0] ns_q;
    logic [CNT_W-1:0] ph_q;

    // Terminating events of a measurement.
    logic             close_hit;
    logic             timeout_hit;

    // Values latched on a clean close.
    logic [CNT_W-1:0] nx_fin;
    logic [CNT_W-1:0] ns_fin;
    logic             sat_fin;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign rise_a = bus.sig_a & ~sig_a_d;
    assign rise_b = bus.sig_b & ~sig_b_d;

    // The closing edge itself is the last A period and the last reference
    // clock, hence the +1 on both counts.
    assign nx_fin = sat_inc(cnt_x);
    assign ns_fin = sat_inc(cnt_s);

    // Counters are monotonic and stick at all-ones, so a counter that ever
    // saturated is all-ones at the end; an all-ones result is therefore
    // treated as untrustworthy.
    assign sat_fin = (nx_fin == CNT_MAX) | (ns_fin == CNT_MAX) | (ph_cnt == CNT_MAX);

    // NOTE: every output of a combinational block gets a default before the
    // case so that no path leaves it unassigned and no latch is inferred.
    always_comb begin
        close_hit   = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            S_ARM: begin
                timeout_hit = ~rise_a & (tmo_cnt == TMO_LAST);
            end
            S_CLOSE: begin
                close_hit   = rise_a;
                timeout_hit = ~rise_a & (tmo_cnt == TMO_LAST);
            end
            default: begin
            end
        endcase
    end

    // NOTE: all state here is updated with non-blocking assignments so every
    // branch sees the pre-edge values of cnt_x, cnt_s, ph_cnt and ph_seen,
    // which is what the latched results are defined against.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            // Edge registers start high: a level already high when reset is
            // released must not be mistaken for a rising edge.
            sig_a_d  <= 1'b1;
            sig_b_d  <= 1'b1;
            cnt_s    <= '0;
            cnt_x    <= '0;
            ph_cnt   <= '0;
            gate_cnt <= '0;
            tmo_cnt  <= '0;
            ph_seen  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ph_vld_q <= 1'b0;
            nx_q     <= '0;
            ns_q     <= '0;
            ph_q     <= '0;
        end else begin
            sig_a_d <= bus.sig_a;
            sig_b_d <= bus.sig_b;
            done_q  <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    cnt_s    <= '0;
                    cnt_x    <= '0;
                    ph_cnt   <= '0;
                    gate_cnt <= '0;
                    tmo_cnt  <= '0;
                    ph_seen  <= 1'b0;
                    if (bus.start) begin
                        state  <= S_ARM;
                        busy_q <= 1'b1;
                    end
                end

                S_ARM: begin
                    tmo_cnt <= tmo_cnt + TMO_ONE;
                    if (rise_a) begin
                        state    <= S_GATE;
                        cnt_s    <= '0;
                        cnt_x    <= '0;
                        gate_cnt <= '0;
                        ph_cnt   <= '0;
                        // B rising together with the opening edge is phase 0.
                        ph_seen  <= rise_b;
                    end
                end

                S_GATE: begin
                    cnt_s    <= sat_inc(cnt_s);
                    gate_cnt <= gate_cnt + CNT_ONE;
                    // An A edge in the last GATE cycle is only counted; the
                    // gate can close no earlier than the next one.
                    if (rise_a) begin
                        cnt_x <= sat_inc(cnt_x);
                    end
                    // The phase count includes the cycle B rises in, then
                    // freezes.
                    if (!ph_seen) begin
                        ph_cnt  <= sat_inc(ph_cnt);
                        ph_seen <= rise_b;
                    end
                    if (gate_cnt == GATE_LAST) begin
                        state   <= S_CLOSE;
                        tmo_cnt <= '0;
                    end
                end

                S_CLOSE: begin
                    cnt_s   <= sat_inc(cnt_s);
                    tmo_cnt <= tmo_cnt + TMO_ONE;
                    if (!ph_seen) begin
                        ph_cnt  <= sat_inc(ph_cnt);
                        ph_seen <= rise_b;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            // A clean close or a timeout both end in DONE; this overrides any
            // state update made above in the same cycle.
            if (close_hit || timeout_hit) begin
                state  <= S_DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
                if (close_hit) begin
                    nx_q     <= nx_fin;
                    ns_q     <= ns_fin;
                    ph_q     <= ph_cnt;
                    ph_vld_q <= ph_seen;
                    err_q    <= sat_fin;
                end else begin
                    nx_q     <= '0;
                    ns_q     <= '0;
                    ph_q     <= '0;
                    ph_vld_q <= 1'b0;
                    err_q    <= 1'b1;
                end
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.nx     = nx_q;
    assign bus.ns     = ns_q;
    assign bus.ph     = ph_q;
    assign bus.ph_vld = ph_vld_q;

endmodule
